count_stream_monitor: RTL and testbench
=======================================

Name: count_stream_monitor

Overview:
Receiving-side checker for the bounded up/down counter's output bus. Samples a count value on each valid strobe and decodes the direction of motion (up/down/hold). Flags illegal steps and out-of-window values, measures dwell at a stable value, and exposes sticky error status to the test/debug logic.

Parameters:
W, 4, width of the observed count and of the lo/hi window bounds.
DWELL_MAX, 8, saturation value of the dwell counter; `settled` asserts when it is reached (1..255).
ERRW, 8, width of the saturating error counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (asserted when 0)
valid_in  input  1  sample strobe; count_in is meaningful only when 1
count_in  input  W  observed counter value
lo  input  W  lower window bound (counter's X)
hi  input  W  upper window bound (counter's Y)
clr_err  input  1  synchronous clear of sticky errors and err_cnt
dir  output  2  decoded state: 00 INIT, 01 UP, 10 DOWN, 11 HOLD
last  output  W  last accepted sample
at_lo  output  1  last == lo at sample time
at_hi  output  1  last == hi at sample time
dwell  output  8  consecutive HOLD samples, saturating at DWELL_MAX
settled  output  1  dwell == DWELL_MAX
step_err  output  1  sticky: illegal step seen
range_err  output  1  sticky: sample outside [lo,hi] seen
bnd_err  output  1  level: lo > hi on the current cycle (combinational)
err_cnt  output  ERRW  saturating count of step and range error events
rev_cnt  output  8  direction reversals (see Optional Feature)

Behaviour:
- Reset (rst==0 at clk edge): dir=INIT, last=0, at_lo=at_hi=0, dwell=0, settled=0, step_err=range_err=0, err_cnt=0, rev_cnt=0. Reset wins over every other input. Mid-stream reset discards history; the next sample is treated as the first.
- All outputs except bnd_err are registered and update on the edge that samples valid_in==1, giving 1-cycle latency. With valid_in==0, everything holds, except the clr_err effects.
- INIT, first valid sample: last=sample, dir=HOLD, dwell=0, no step check. The range check still applies.
- Other states, valid sample s versus last p (unsigned, W bits, no modular arithmetic):
  - s==p+1 with p != all-ones: dir=UP, dwell=0.
  - s==p-1 with p != 0: dir=DOWN, dwell=0.
  - s==p: dir=HOLD, dwell=min(dwell+1, DWELL_MAX).
  - Anything else, including wrap all-ones->0 and 0->all-ones: step_err=1, err_cnt+1, dir unchanged, dwell=0.
  - In every case last=s.
- Range check on every valid sample when lo<=hi: if s<lo or s>hi, then range_err=1 and err_cnt+1. If lo>hi, bnd_err=1 and the range check is suppressed (no range_err). The step check is still performed.
- A sample with both step and range errors increments err_cnt by 2. err_cnt saturates at all-ones and never wraps.
- at_lo/at_hi are computed from s and the lo/hi values at the sampling edge, and are held until the next valid sample.
- clr_err==1 clears step_err, range_err and err_cnt on that edge. If an error event occurs on the same edge, the event wins: the flag is set and err_cnt equals that event's increment (1 or 2).
- settled is a registered level: 1 iff the dwell register equals DWELL_MAX.

Optional Feature:
Macro COUNT_MON_REVERSAL_EN.
- Defined: rev_cnt increments (saturating at 255) on each UP->DOWN or DOWN->UP change of the last non-HOLD direction. HOLD between the two directions does not break the pairing. An error sample leaves the last direction unchanged. Reset and INIT clear the stored direction. clr_err does not affect rev_cnt.
- Undefined: the rev_cnt port remains and is tied to 0; no reversal logic is synthesized.

Test Plan:
- Reset then ramp: rst=0 for 2 cycles -> all outputs 0, dir=00. Release with lo=3, hi=6, samples 3,4,5,6 -> dir 11,01,01,01; at_lo=1 after sample 3; at_hi=1 after sample 6; errors 0.
- Dwell: samples 6 repeated 10 times with DWELL_MAX=8 -> dir=HOLD, dwell 1..8 then stays 8, settled=1 from the 8th repeat. Next sample 5 -> dir=DOWN, dwell=0, settled=0.
- Illegal steps: samples 3,5 -> step_err=1, err_cnt=1, dir unchanged. Samples 15,0 (lo=0, hi=15) -> wrap flagged, err_cnt=2.
- Range and bounds: lo=3, hi=6, sample 7 after 6 -> range_err=1, err_cnt=1, step ok (dir=UP). Set lo=9, hi=2 -> bnd_err=1, sample 12 -> no range_err increment.
- Clear/simultaneous: assert clr_err alone -> flags and err_cnt=0. Assert clr_err on the same edge as a jump 3->8 with lo=3, hi=6 -> step_err=1, range_err=1, err_cnt=2.
- Reversal (macro defined): samples 3,4,5,5,4,3,4 -> rev_cnt=2. Macro undefined -> rev_cnt stays 0. Then rst mid-stream -> dir=INIT, rev_cnt=0.

Source files
------------

// File: rtl/count_stream_monitor.sv
// rtl/count_stream_monitor.sv - receive-side checker for a bounded up/down counter bus (option: COUNT_MON_REVERSAL_EN)
module count_stream_monitor #(
    parameter int W         = 4,
    parameter int DWELL_MAX = 8,
    parameter int ERRW      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [W-1:0]    count_in,
    input  logic [W-1:0]    lo,
    input  logic [W-1:0]    hi,
    input  logic            clr_err,
    output logic [1:0]      dir,
    output logic [W-1:0]    last,
    output logic            at_lo,
    output logic            at_hi,
    output logic [7:0]      dwell,
    output logic            settled,
    output logic            step_err,
    output logic            range_err,
    output logic            bnd_err,
    output logic [ERRW-1:0] err_cnt,
    output logic [7:0]      rev_cnt
);
    localparam logic [1:0] S_INIT = 2'b00;
    localparam logic [1:0] S_UP   = 2'b01;
    localparam logic [1:0] S_DOWN = 2'b10;
    localparam logic [1:0] S_HOLD = 2'b11;
    localparam logic [7:0] DMAX   = 8'(DWELL_MAX);
    localparam int         EW1    = ERRW + 1;

    logic [1:0]      state_q, state_n;
    logic [W-1:0]    last_q, last_n;
    logic            at_lo_q, at_lo_n, at_hi_q, at_hi_n;
    logic [7:0]      dwell_q, dwell_n;
    logic            settled_q, settled_n;
    logic            step_q, step_n, range_q, range_n;
    logic [ERRW-1:0] err_q, err_n, err_base;
    logic [ERRW:0]   err_sum;
    logic [1:0]      err_inc;
    logic            bnd, step_bad, range_bad;
    logic            is_up, is_dn, is_eq;
    logic [7:0]      rev_q;

    assign bnd   = lo > hi;
    // Strict +/-1 steps; the all-ones/zero edges are excluded so wraps count as illegal.
    assign is_up = (last_q != {W{1'b1}}) && (count_in == last_q + W'(1));
    assign is_dn = (last_q != {W{1'b0}}) && (count_in == last_q - W'(1));
    assign is_eq = (count_in == last_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_INIT;
            last_q    <= '0;
            at_lo_q   <= 1'b0;
            at_hi_q   <= 1'b0;
            dwell_q   <= '0;
            settled_q <= 1'b0;
            step_q    <= 1'b0;
            range_q   <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_n;
            last_q    <= last_n;
            at_lo_q   <= at_lo_n;
            at_hi_q   <= at_hi_n;
            dwell_q   <= dwell_n;
            settled_q <= settled_n;
            step_q    <= step_n;
            range_q   <= range_n;
            err_q     <= err_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        last_n    = last_q;
        at_lo_n   = at_lo_q;
        at_hi_n   = at_hi_q;
        dwell_n   = dwell_q;
        step_n    = step_q;
        range_n   = range_q;
        err_base  = err_q;
        step_bad  = 1'b0;
        range_bad = 1'b0;
        if (clr_err) begin
            step_n   = 1'b0;
            range_n  = 1'b0;
            err_base = '0;
        end
        if (valid_in) begin
            last_n    = count_in;
            at_lo_n   = (count_in == lo);
            at_hi_n   = (count_in == hi);
            range_bad = !bnd && ((count_in < lo) || (count_in > hi));
            if (state_q == S_INIT) begin
                state_n = S_HOLD;
                dwell_n = '0;
            end else if (is_up) begin
                state_n = S_UP;
                dwell_n = '0;
            end else if (is_dn) begin
                state_n = S_DOWN;
                dwell_n = '0;
            end else if (is_eq) begin
                state_n = S_HOLD;
                dwell_n = (dwell_q >= DMAX) ? DMAX : dwell_q + 8'd1;
            end else begin
                step_bad = 1'b1;
                dwell_n  = '0;
            end
        end
        if (step_bad)  step_n  = 1'b1;
        if (range_bad) range_n = 1'b1;
        err_inc   = {1'b0, step_bad} + {1'b0, range_bad};
        err_sum   = {1'b0, err_base} + EW1'(err_inc);
        err_n     = err_sum[ERRW] ? {ERRW{1'b1}} : err_sum[ERRW-1:0];
        settled_n = (dwell_n == DMAX);
    end

`ifdef COUNT_MON_REVERSAL_EN
    // Last non-HOLD direction: 00 none, 01 up, 10 down.
    logic [1:0] ldir_q;
    logic       rev_hit;

    assign rev_hit = valid_in && (state_q != S_INIT) &&
                     ((is_up && ldir_q == S_DOWN) || (is_dn && ldir_q == S_UP));

    always_ff @(posedge clk) begin
        if (!rst) begin
            ldir_q <= S_INIT;
            rev_q  <= '0;
        end else if (valid_in) begin
            if (state_q == S_INIT) begin
                ldir_q <= S_INIT;
            end else if (is_up) begin
                ldir_q <= S_UP;
            end else if (is_dn) begin
                ldir_q <= S_DOWN;
            end
            if (rev_hit && rev_q != 8'hff) begin
                rev_q <= rev_q + 8'd1;
            end
        end
    end
`else
    assign rev_q = '0;
`endif

    always_comb begin
        dir       = state_q;
        last      = last_q;
        at_lo     = at_lo_q;
        at_hi     = at_hi_q;
        dwell     = dwell_q;
        settled   = settled_q;
        step_err  = step_q;
        range_err = range_q;
        bnd_err   = bnd;
        err_cnt   = err_q;
        rev_cnt   = rev_q;
    end
endmodule

// File: tb/tb_count_stream_monitor.sv
// tb/tb_count_stream_monitor.sv - table-driven bench for count_stream_monitor
module tb_count_stream_monitor;
    logic       clk = 1'b0;
    logic       rst, valid_in, clr_err;
    logic [3:0] count_in, lo, hi;
    logic [1:0] dir;
    logic [3:0] last;
    logic       at_lo, at_hi, settled, step_err, range_err, bnd_err;
    logic [7:0] dwell, err_cnt, rev_cnt;

    int checks = 0;
    int failures = 0;

`ifdef COUNT_MON_REVERSAL_EN
    localparam int REV_EXP = 2;
`else
    localparam int REV_EXP = 0;
`endif

    count_stream_monitor #(.W(4), .DWELL_MAX(8), .ERRW(8)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .count_in(count_in),
        .lo(lo), .hi(hi), .clr_err(clr_err), .dir(dir), .last(last),
        .at_lo(at_lo), .at_hi(at_hi), .dwell(dwell), .settled(settled),
        .step_err(step_err), .range_err(range_err), .bnd_err(bnd_err),
        .err_cnt(err_cnt), .rev_cnt(rev_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, v, clr;
        logic [3:0] c, l, h;
        logic [1:0] e_dir;
        logic [3:0] e_last;
        logic       e_alo, e_ahi;
        logic [7:0] e_dwell;
        logic       e_set, e_se, e_re, e_bnd;
        logic [7:0] e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int r, int v, int c, int l, int h, int clr,
                                int d, int ls, int alo, int ahi, int dw,
                                int st, int se, int re, int bd, int er);
        vec_t x;
        x.r = r[0]; x.v = v[0]; x.c = c[3:0]; x.l = l[3:0]; x.h = h[3:0]; x.clr = clr[0];
        x.e_dir = d[1:0]; x.e_last = ls[3:0]; x.e_alo = alo[0]; x.e_ahi = ahi[0];
        x.e_dwell = dw[7:0]; x.e_set = st[0]; x.e_se = se[0]; x.e_re = re[0];
        x.e_bnd = bd[0]; x.e_err = er[7:0];
        vecs.push_back(x);
    endfunction

    task automatic drive(input logic r, input logic v, input logic [3:0] c,
                         input logic [3:0] l, input logic [3:0] h, input logic clr);
        rst = r; valid_in = v; count_in = c; lo = l; hi = h; clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin
        logic [33:0] act, exp;
        //   r v  c lo hi clr | dir last alo ahi dwell set se re bnd err
        add(0, 1, 5, 3, 6, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 3, 6, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 3, 3, 6, 0,   3, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 4, 3, 6, 0,   1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 5, 3, 6, 0,   1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 6, 3, 6, 0,   1, 6, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++)
            add(1, 1, 6, 3, 6, 0, 3, 6, 0, 1, (k > 8) ? 8 : k, (k >= 8) ? 1 : 0, 0, 0, 0, 0);
        add(1, 1, 5, 3, 6, 0,   2, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 9, 3, 6, 0,   2, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 3, 3, 6, 0,   2, 3, 1, 0, 0, 0, 1, 0, 0, 1);
        add(1, 0, 3, 3, 6, 1,   2, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 5, 3, 6, 0,   2, 5, 0, 0, 0, 0, 1, 0, 0, 1);
        add(1, 0, 5, 3, 6, 1,   2, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 15, 0, 15, 0, 2, 15, 0, 1, 0, 0, 1, 0, 0, 1);
        add(1, 1, 0, 0, 15, 0,  2, 0, 1, 0, 0, 0, 1, 0, 0, 2);
        add(0, 0, 0, 3, 6, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 6, 3, 6, 0,   3, 6, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 7, 3, 6, 0,   1, 7, 0, 0, 0, 0, 0, 1, 0, 1);
        add(1, 0, 7, 9, 2, 0,   1, 7, 0, 0, 0, 0, 0, 1, 1, 1);
        add(1, 1, 8, 9, 2, 0,   1, 8, 0, 0, 0, 0, 0, 1, 1, 1);
        add(1, 1, 3, 3, 6, 0,   1, 3, 1, 0, 0, 0, 1, 1, 0, 2);
        add(1, 1, 8, 3, 6, 1,   1, 8, 0, 0, 0, 0, 1, 1, 0, 2);
        add(1, 0, 8, 3, 6, 1,   1, 8, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].v, vecs[i].c, vecs[i].l, vecs[i].h, vecs[i].clr);
            act = {dir, last, at_lo, at_hi, dwell, settled, step_err, range_err, bnd_err, err_cnt};
            exp = {vecs[i].e_dir, vecs[i].e_last, vecs[i].e_alo, vecs[i].e_ahi, vecs[i].e_dwell,
                   vecs[i].e_set, vecs[i].e_se, vecs[i].e_re, vecs[i].e_bnd, vecs[i].e_err};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL vec%0d actual=%h required=%h", i, act, exp);
            end
        end
        chk("rev_no_change", int'(rev_cnt), 0);

        // err_cnt saturation: every 0<->15 hop with window [5,10] is a step and a range error.
        drive(0, 0, 0, 5, 10, 0);
        drive(1, 1, 0, 5, 10, 0);
        drive(1, 1, 15, 5, 10, 0);
        drive(1, 1, 0, 5, 10, 0);
        chk("err_plus2", int'(err_cnt), 5);
        for (int k = 0; k < 130; k++)
            drive(1, 1, (k % 2 == 0) ? 4'd15 : 4'd0, 5, 10, 0);
        chk("err_sat", int'(err_cnt), 255);
        drive(1, 1, 15, 5, 10, 0);
        chk("err_no_wrap", int'(err_cnt), 255);

        // Reversals, HOLD in between does not break the pairing.
        drive(0, 0, 0, 0, 15, 0);
        drive(1, 1, 3, 0, 15, 0);
        drive(1, 1, 4, 0, 15, 0);
        drive(1, 1, 5, 0, 15, 0);
        drive(1, 1, 5, 0, 15, 0);
        drive(1, 1, 4, 0, 15, 0);
        chk("rev_after_hold", int'(rev_cnt), REV_EXP / 2);
        drive(1, 1, 3, 0, 15, 0);
        drive(1, 1, 4, 0, 15, 0);
        chk("rev_cnt", int'(rev_cnt), REV_EXP);
        chk("rev_dir", int'(dir), 1);
        drive(1, 0, 4, 0, 15, 1);
        chk("rev_clr_keeps", int'(rev_cnt), REV_EXP);
        drive(0, 1, 5, 0, 15, 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_rev", int'(rev_cnt), 0);
        drive(1, 1, 9, 0, 15, 0);
        chk("first_after_rst", int'({dir, last, step_err}), int'({2'b11, 4'd9, 1'b0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
